// File: rtl/if_id_latch.sv
// IF/ID pipeline register with stall/flush handling and the HLT drain-then-halt sequence.
// Optional IF_ID_STATS_EN adds saturating stall/flush event counters.
module if_id_latch #(
    parameter logic [15:0] NOP_INSTR    = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE   = 4'hF,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_plus_1,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus_1,
    output logic        id_valid,
    output logic        fetch_hlt,
    output logic        hlt
`ifdef IF_ID_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        hlt_q, hlt_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halt_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
            hlt_q   <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hlt_q   <= hlt_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (halt_seen) begin
                    state_d = StDrain;
                    cnt_d   = DrainInit;
                end
            end
            StDrain: begin
                if (cnt_q == 4'd0) state_d = StHalted;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
        hlt_d = (state_d == StHalted);
    end

    // The edge on which HLT leaves decode already loads a bubble, so id_valid drops after it.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (state_q != StRun || halt_seen || flush) begin
            instr_d = NOP_INSTR;
            pc_d    = 16'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = if_instr;
            pc_d    = if_pc_plus_1;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        halt_seen = (state_q == StRun) && valid_q && (instr_q[15:12] == HLT_OPCODE)
                    && !stall && !flush;
        fetch_hlt    = halt_seen || (state_q != StRun);
        hlt          = hlt_q;
        id_instr     = instr_q;
        id_pc_plus_1 = pc_q;
        id_valid     = valid_q;
    end

`ifdef IF_ID_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (state_q == StRun && stall && !flush && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (state_q == StRun && flush && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// Directed self-checking bench for if_id_latch; define IF_ID_STATS_EN to also check counters.
module tb_if_id_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_instr, if_pc_plus_1;
    logic        stall, flush;
    logic [15:0] id_instr, id_pc_plus_1;
    logic        id_valid, fetch_hlt, hlt;
`ifdef IF_ID_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    if_id_latch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_instr     (if_instr),
        .if_pc_plus_1 (if_pc_plus_1),
        .stall        (stall),
        .flush        (flush),
        .id_instr     (id_instr),
        .id_pc_plus_1 (id_pc_plus_1),
        .id_valid     (id_valid),
        .fetch_hlt    (fetch_hlt),
        .hlt          (hlt)
`ifdef IF_ID_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_instr = 16'h0; if_pc_plus_1 = 16'h0; stall = 1'b0; flush = 1'b0;
        #2;
        checks++; if (id_instr !== 16'h0000) begin failures++; $display("FAIL rst_instr got %h want 0000", id_instr); end
        checks++; if (id_pc_plus_1 !== 16'h0) begin failures++; $display("FAIL rst_pc got %h want 0000", id_pc_plus_1); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", id_valid); end
        checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL rst_hlt got %b want 0", hlt); end
        checks++; if (fetch_hlt !== 1'b0) begin failures++; $display("FAIL rst_fetch_hlt got %b want 0", fetch_hlt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        if_instr = 16'h1234; if_pc_plus_1 = 16'd1;
        tick();
        checks++; if (id_instr !== 16'h1234 || id_pc_plus_1 !== 16'd1 || id_valid !== 1'b1) begin
            failures++; $display("FAIL load1 got %h/%h/%b want 1234/0001/1", id_instr, id_pc_plus_1, id_valid); end
        if_instr = 16'h2345; if_pc_plus_1 = 16'd2;
        tick();
        checks++; if (id_instr !== 16'h2345 || id_pc_plus_1 !== 16'd2 || id_valid !== 1'b1) begin
            failures++; $display("FAIL load2 got %h/%h/%b want 2345/0002/1", id_instr, id_pc_plus_1, id_valid); end
    endtask

    task automatic test_stall();
        if_instr = 16'h1234; if_pc_plus_1 = 16'd5;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_instr = 16'hA000 + 16'(i); if_pc_plus_1 = 16'd20 + 16'(i);
            tick();
            checks++; if (id_instr !== 16'h1234 || id_pc_plus_1 !== 16'd5 || id_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got %h/%h/%b want 1234/0005/1", i, id_instr, id_pc_plus_1, id_valid); end
        end
        stall = 1'b0; if_instr = 16'hB0B0; if_pc_plus_1 = 16'd9;
        tick();
        checks++; if (id_instr !== 16'hB0B0 || id_pc_plus_1 !== 16'd9) begin
            failures++; $display("FAIL stall_release got %h/%h want b0b0/0009", id_instr, id_pc_plus_1); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush = 1'b1; if_instr = 16'h7777; if_pc_plus_1 = 16'd7;
        tick();
        checks++; if (id_instr !== 16'h0000 || id_pc_plus_1 !== 16'd0 || id_valid !== 1'b0) begin
            failures++; $display("FAIL stall_flush got %h/%h/%b want 0000/0000/0", id_instr, id_pc_plus_1, id_valid); end
        stall = 1'b0; flush = 1'b0;
`ifdef IF_ID_STATS_EN
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
        checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got %0d want 1", flush_cnt); end
`endif
    endtask

    task automatic test_flushed_hlt();
        if_instr = 16'hF000; if_pc_plus_1 = 16'd3;
        tick();
        flush = 1'b1; if_instr = 16'h1111; if_pc_plus_1 = 16'd4;
        #1;
        checks++; if (fetch_hlt !== 1'b0) begin failures++; $display("FAIL flushed_hlt_fetch got %b want 0", fetch_hlt); end
        tick();
        flush = 1'b0;
        tick();
        checks++; if (fetch_hlt !== 1'b0 || hlt !== 1'b0 || id_instr !== 16'h1111) begin
            failures++; $display("FAIL flushed_hlt_run got %b/%b/%h want 0/0/1111", fetch_hlt, hlt, id_instr); end
    endtask

    task automatic test_stalled_hlt();
        if_instr = 16'hF000; if_pc_plus_1 = 16'd6;
        tick();
        stall = 1'b1; if_instr = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fetch_hlt !== 1'b0) begin failures++; $display("FAIL stalled_hlt_fetch%0d got %b want 0", i, fetch_hlt); end
            tick();
        end
        checks++; if (id_instr !== 16'hF000 || id_valid !== 1'b1) begin
            failures++; $display("FAIL stalled_hlt_hold got %h/%b want f000/1", id_instr, id_valid); end
        stall = 1'b0;
        #1;
        checks++; if (fetch_hlt !== 1'b1) begin failures++; $display("FAIL stalled_hlt_release got %b want 1", fetch_hlt); end
        tick();
        checks++; if (id_valid !== 1'b0 || fetch_hlt !== 1'b1 || hlt !== 1'b0) begin
            failures++; $display("FAIL drain_e got %b/%b/%b want 0/1/0", id_valid, fetch_hlt, hlt); end
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++; if (hlt !== 1'b0 || id_valid !== 1'b0) begin
                failures++; $display("FAIL drain_e%0d got %b/%b want 0/0", i, hlt, id_valid); end
        end
        tick();
        checks++; if (hlt !== 1'b1) begin failures++; $display("FAIL hlt_rise got %b want 1", hlt); end
        flush = 1'b1; stall = 1'b1; if_instr = 16'h1234; if_pc_plus_1 = 16'd1;
        tick();
        tick();
        checks++; if (hlt !== 1'b1 || fetch_hlt !== 1'b1 || id_valid !== 1'b0 || id_instr !== 16'h0000) begin
            failures++; $display("FAIL halted_sticky got %b/%b/%b/%h want 1/1/0/0000", hlt, fetch_hlt, id_valid, id_instr); end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_halt_reset_mid_drain();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        if_instr = 16'hF000; if_pc_plus_1 = 16'd8;
        tick();
        if_instr = 16'h3333;
        #1;
        checks++; if (fetch_hlt !== 1'b1) begin failures++; $display("FAIL hlt_same_cycle got %b want 1", fetch_hlt); end
        tick();
        tick();
        checks++; if (hlt !== 1'b0 || fetch_hlt !== 1'b1) begin
            failures++; $display("FAIL drain_mid got %b/%b want 0/1", hlt, fetch_hlt); end
        rst_n = 1'b0;
        #1;
        checks++; if (hlt !== 1'b0 || fetch_hlt !== 1'b0 || id_valid !== 1'b0) begin
            failures++; $display("FAIL mid_drain_reset got %b/%b/%b want 0/0/0", hlt, fetch_hlt, id_valid); end
`ifdef IF_ID_STATS_EN
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++; $display("FAIL stats_reset got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
        #2;
        rst_n = 1'b1;
        if_instr = 16'h4567; if_pc_plus_1 = 16'd12;
        tick();
        checks++; if (id_instr !== 16'h4567 || id_pc_plus_1 !== 16'd12 || id_valid !== 1'b1 || hlt !== 1'b0) begin
            failures++; $display("FAIL post_reset_load got %h/%h/%b/%b want 4567/000c/1/0", id_instr, id_pc_plus_1, id_valid, hlt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_stall_flush();
        test_flushed_hlt();
        test_stalled_hlt();
        test_halt_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
